ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the opposite direction of the existing keyboard receiver (kbd). It sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Drives KBD_CLK and KBD_DATA open-drain, using the standard PS/2 request-to-send sequence, and checks the device ACK.
- Sits beside kbd in the top level, on the same 24 MHz clk.
- busy gates the kbd receiver so the receiver ignores frames while the host is transmitting.

Parameters:
- CLK_HZ, 24000000, system clock frequency (documentation only).
- INHIBIT_CYCLES, 2400, cycles the host holds the clock low to request send (100 us at 24 MHz).
- TIMEOUT_CYCLES, 360000, maximum cycles from clock release to end of ACK (15 ms).
- FILTER_LEN, 4, number of consecutive equal synchronized samples needed to accept a line level.

Ports:
- clk  in  1  system clock (24 MHz)
- resetn  in  1  reset; one clock; reset is synchronous and active-low
- txData  in  8  command byte to send
- txValid  in  1  request; accepted when txValid && txReady
- txReady  out  1  high only in IDLE
- kbdClkIn  in  1  raw KBD_CLK pad level
- kbdDataIn  in  1  raw KBD_DATA pad level
- kbdClkOe  out  1  1 = pull KBD_CLK low; 0 = release
- kbdDataOe  out  1  1 = pull KBD_DATA low; 0 = release
- busy  out  1  high in every state except IDLE
- txDone  out  1  one-cycle pulse when a frame completes with ACK
- txError  out  1  one-cycle pulse on timeout or missing ACK

Behaviour:
- Reset (synchronous, resetn=0 sampled at a clk edge):
  - kbdClkOe=0, kbdDataOe=0, busy=0, txDone=0, txError=0, txReady=1.
  - State=IDLE; all counters cleared.
  - Reset mid-frame releases both lines on that same edge. No pulse is emitted.
- Input conditioning:
  - Each raw line passes through a 2-FF synchronizer, then a filter. The filtered level changes only after FILTER_LEN consecutive equal samples.
  - Filter reset value is 1.
  - fallClk is a one-cycle pulse when filtered clk goes 1->0. Latency from pad edge is 2+FILTER_LEN cycles.
- Byte accept: shift register = {stop=1, parity=~^txData, txData}, LSB first, 10 bits. Odd parity.
- IDLE:
  - txReady=1.
  - On accept: latch frame, kbdClkOe=1, go INHIBIT.
  - txValid while not in IDLE is ignored; the byte is not queued.
- INHIBIT:
  - Count INHIBIT_CYCLES with kbdClkOe=1.
  - In the final count cycle, set kbdDataOe=1 (start bit). On the next cycle set kbdClkOe=0 and go SHIFT.
  - Clear the timeout counter on entry to SHIFT.
- SHIFT:
  - On each fallClk, kbdDataOe = ~frame[bitCnt] and bitCnt increments.
  - Falls 1-8 present D0-D7, fall 9 presents parity, fall 10 presents stop (kbdDataOe=0).
  - After fall 10, go ACK.
- ACK:
  - On the next fallClk, sample filtered data.
  - Data 0: go WAIT_IDLE.
  - Data 1: pulse txError, go IDLE.
- WAIT_IDLE:
  - Wait until filtered clk=1 and data=1 together, then pulse txDone and go IDLE.
- Timeout:
  - The counter runs in SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces kbdClkOe=0 and kbdDataOe=0, pulses txError, and returns to IDLE on the next cycle.
  - Timeout has priority over a simultaneous fallClk.
- Mutual exclusion: txDone and txError never assert in the same cycle. Exactly one of them pulses per accepted byte, unless reset intervenes.
- The host never drives a line high. The Oe outputs are the only drive.

Decomposition:
- Package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE.
  - frame length constant (10).
  - parity function.
  - default timing constants.
- Sub-module ps2_line_filter: 2-FF synchronizer plus FILTER_LEN filter, reset level 1. Instantiated twice (clk, data).
- ps2_line_filter is reusable by kbd.

Test Plan:
- Send 0xED; the bench device model clocks at 12.5 kHz and ACKs.
  - Expect kbdClkOe low for exactly 2400 cycles, then data bits 1,0,1,1,0,1,1,1 followed by parity=1 and stop.
  - Expect txDone one pulse, no txError.
- Send 0xF4 (parity 0) and 0x00 (parity 1): check the parity bit on the line at fall 9 for each. After each, txReady=1 and busy=0.
- Device never clocks after request: txError pulses 360000 cycles after clock release, both Oe=0, state IDLE.
- Device clocks all 11 edges but holds data high at the ACK edge: txError pulses, txDone stays 0.
- resetn=0 for one cycle during bit 4 of 0xFF: both Oe=0 on the next edge, no pulses, and a following 0xF4 send completes normally.
- Clock glitch of FILTER_LEN-1 cycles injected mid-frame: no extra bit is shifted, and the frame for 0xED remains correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, constants and helpers for the PS/2 host transmitter
// and the line conditioning used by both transmit and receive paths.
//   state_t      - host transmit FSM states
//   FRAME_LEN    - bits shifted after the start bit (8 data, parity, stop)
//   DEF_*        - default timing constants for a 24 MHz system clock
//   odd_parity() - parity bit that makes the 9-bit data+parity word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int unsigned FRAME_LEN          = 10;
  localparam int unsigned DEF_CLK_HZ         = 24000000;
  localparam int unsigned DEF_INHIBIT_CYCLES = 2400;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 360000;
  localparam int unsigned DEF_FILTER_LEN     = 4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pad level (KBD_CLK or KBD_DATA).
// Two-flop synchronizer followed by a run-length filter: the output level
// only changes after FILTER_LEN consecutive synchronized samples disagree
// with it. Reset level is 1 (idle bus).
// Ports:
//   clk    - system clock
//   resetn - synchronous active-low reset
//   raw    - asynchronous pad level
//   level  - filtered, synchronous line level
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  // run_cnt counts samples differing from level; the FILTER_LEN-th one flips it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      run_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        level   <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Performs the request-to-send sequence (clock inhibit, start bit, clock
// release), shifts data/parity/stop on device clock falls, checks the device
// ACK and waits for the bus to return idle. Lines are open-drain: the *Oe
// outputs only ever pull low.
// Ports:
//   clk, resetn          - 24 MHz clock, synchronous active-low reset
//   txData/txValid/txReady - command byte handshake (accepted in IDLE only)
//   kbdClkIn/kbdDataIn   - raw pad levels
//   kbdClkOe/kbdDataOe   - 1 = pull line low
//   busy                 - transfer in progress (gates the kbd receiver)
//   txDone/txError       - one-cycle completion / failure pulses
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  input  logic       kbdClkIn,
  input  logic       kbdDataIn,
  output logic       kbdClkOe,
  output logic       kbdDataOe,
  output logic       busy,
  output logic       txDone,
  output logic       txError
);

  if (CLK_HZ == 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN == 0) begin : g_bad_params
    $error("ps2_host_tx: invalid timing parameters");
  end

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

  logic clk_lvl;
  logic data_lvl;
  logic clk_prev;
  logic fall_clk;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .resetn (resetn),
    .raw    (kbdClkIn),
    .level  (clk_lvl)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .resetn (resetn),
    .raw    (kbdDataIn),
    .level  (data_lvl)
  );

  assign fall_clk = clk_prev & ~clk_lvl;

  state_t             state_q, state_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [3:0]         bit_q, bit_d;
  logic [INH_W-1:0]   inh_q, inh_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      bit_q     <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_prev  <= 1'b1;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      clk_prev  <= clk_lvl;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    inh_d     = inh_q;
    to_d      = to_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (txValid) begin
          frame_d   = {1'b1, odd_parity(txData), txData};
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          inh_d     = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_d = inh_q + INH_W'(1);
        // Start bit goes out one cycle before the clock is released.
        if (inh_q == INH_W'(INHIBIT_CYCLES - 2)) begin
          data_oe_d = 1'b1;
        end
        if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          bit_d    = '0;
          to_d     = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        to_d = to_q + TO_W'(1);
        if (fall_clk) begin
          data_oe_d = ~frame_q[bit_q];
          bit_d     = bit_q + 4'd1;
          if (bit_q == 4'(FRAME_LEN - 1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        to_d = to_q + TO_W'(1);
        if (fall_clk) begin
          if (data_lvl) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        to_d = to_q + TO_W'(1);
        if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout overrides whatever the state logic decided this cycle.
    if ((state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) &&
        to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = IDLE;
    end
  end

  assign kbdClkOe  = clk_oe_q;
  assign kbdDataOe = data_oe_q;
  assign txDone    = done_q;
  assign txError   = err_q;
  assign txReady   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  // Shortened timeout and a fast device clock keep the run short.
  localparam int unsigned INH  = 2400;
  localparam int unsigned TO   = 5000;
  localparam int unsigned HALF = 100;

  localparam int M_OK     = 0;
  localparam int M_SILENT = 1;
  localparam int M_NOACK  = 2;
  localparam int M_RESET  = 3;
  localparam int M_GLITCH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady, kbdClkOe, kbdDataOe, busy, txDone, txError;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       kbd_clk, kbd_data;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #20 clk = ~clk;

  assign kbd_clk  = ~(kbdClkOe | dev_clk_low);
  assign kbd_data = ~(kbdDataOe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ         (24000000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .kbdClkIn  (kbd_clk),
    .kbdDataIn (kbd_data),
    .kbdClkOe  (kbdClkOe),
    .kbdDataOe (kbdDataOe),
    .busy      (busy),
    .txDone    (txDone),
    .txError   (txError)
  );

  always @(negedge clk) begin
    if (txDone === 1'b1) done_cnt++;
    if (txError === 1'b1) err_cnt++;
    if (txDone === 1'b1 && txError === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input string nm, input logic [7:0] b, input logic [9:0] exp, input int mode);
    int n, d0, e0;
    logic [9:0] got;
    bit aborted;
    got = '0;
    aborted = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    check({nm, "/ready"}, txReady, 1);
    txData  = b;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    txData  = 8'h55;
    check({nm, "/busy"}, busy, 1);
    n = 0;
    while (kbdClkOe === 1'b1 && n < 3 * INH) begin
      @(negedge clk);
      n++;
    end
    check({nm, "/inhibit_len"}, n, INH);
    check({nm, "/start_bit"}, kbdDataOe, 1);

    if (mode == M_SILENT) begin
      n = 0;
      while (txError !== 1'b1 && n < 2 * TO) begin
        @(negedge clk);
        n++;
      end
      check({nm, "/timeout_len"}, n, TO);
      check({nm, "/to_clk_oe"}, kbdClkOe, 0);
      check({nm, "/to_data_oe"}, kbdDataOe, 0);
    end else begin
      repeat (20) @(negedge clk);
      for (int i = 1; i <= 11 && !aborted; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        if (mode == M_RESET && i == 4) begin
          resetn = 1'b0;
          @(negedge clk);
          check({nm, "/rst_clk_oe"}, kbdClkOe, 0);
          check({nm, "/rst_data_oe"}, kbdDataOe, 0);
          check({nm, "/rst_busy"}, busy, 0);
          resetn = 1'b1;
          dev_clk_low = 1'b0;
          aborted = 1;
          repeat (4 * HALF) @(negedge clk);
        end else begin
          dev_clk_low = 1'b0;
          if (i <= 10) got[i-1] = kbd_data;
          if (i == 10 && mode != M_NOACK) dev_data_low = 1'b1;
          for (int k = 0; k < int'(HALF); k++) begin
            txValid = (i == 3 && k == 10);
            if (mode == M_GLITCH && i == 5) dev_clk_low = (k >= 40 && k < 43);
            @(negedge clk);
          end
          txValid = 1'b0;
          dev_clk_low = 1'b0;
          if (i == 11) dev_data_low = 1'b0;
        end
      end
      if (mode == M_OK || mode == M_GLITCH) begin
        n = 0;
        while (txDone !== 1'b1 && txError !== 1'b1 && n < int'(TO)) begin
          @(negedge clk);
          n++;
        end
      end
    end

    repeat (3) @(negedge clk);
    if (mode == M_OK || mode == M_GLITCH || mode == M_NOACK) begin
      check({nm, "/bits"}, got, exp);
      check({nm, "/parity_fall9"}, got[8], exp[8]);
    end
    check({nm, "/done_pulses"}, done_cnt - d0, (mode == M_OK || mode == M_GLITCH) ? 1 : 0);
    check({nm, "/err_pulses"}, err_cnt - e0, (mode == M_SILENT || mode == M_NOACK) ? 1 : 0);
    check({nm, "/end_ready"}, txReady, 1);
    check({nm, "/end_busy"}, busy, 0);
    check({nm, "/end_clk_oe"}, kbdClkOe, 0);
    check({nm, "/end_data_oe"}, kbdDataOe, 0);
  endtask

  initial begin
    #8000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    txValid = 1'b0;
    txData  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset/ready", txReady, 1);
    check("reset/busy", busy, 0);
    check("reset/clk_oe", kbdClkOe, 0);
    check("reset/data_oe", kbdDataOe, 0);
    check("reset/done", txDone, 0);
    check("reset/err", txError, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // Expected line bits D0..D7, parity, stop (LSB = first bit on the wire).
    send("ed",     8'hED, 10'h3ED, M_OK);
    send("f4",     8'hF4, 10'h2F4, M_OK);
    send("zero",   8'h00, 10'h300, M_OK);
    send("silent", 8'hED, 10'h3ED, M_SILENT);
    send("noack",  8'hF4, 10'h2F4, M_NOACK);
    send("rst_ff", 8'hFF, 10'h3FF, M_RESET);
    send("f4_2",   8'hF4, 10'h2F4, M_OK);
    send("glitch", 8'hED, 10'h3ED, M_GLITCH);

    check("done_err_exclusive", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
